reg16_004_write_arbiter: RTL
============================

Name: reg16_004_write_arbiter

Overview:
- Shares write access to the 16-bit SDMA buffer-boundary / transfer-block-size register between three requesters.
- Grants one requester at a time in round-robin order and drives exactly one of the register's three enable lines for one cycle.
- Confirms the write via the register's ack and returns a per-requester done/err.
- Sits between the host-interface requesters and the register instance, so the register's busy (collision) condition never occurs.

Parameters:
- DW, 15, write payload width: {sdmabuffb[2:0], bsize[11:0]}; bit 15 of the register is constant 0 and not carried.
- TIMEOUT, 8, number of WAIT cycles without reg_ack before the transaction is aborted with err; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  3  per-requester write request, level; bit i = requester i
- wdata0  in  DW  requester 0 payload, [14:12]=sdmabuffb, [11:0]=bsize
- wdata1  in  DW  requester 1 payload
- wdata2  in  DW  requester 2 payload
- gnt  out  3  one-hot grant, high from ISSUE through DONE inclusive
- done  out  3  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with done when the transaction timed out or saw reg_busy
- busy  out  1  high whenever state != IDLE
- reg_enb  out  3  one-hot enable to register block0/1/2, high only in ISSUE
- reg_bsize  out  12  payload bsize to register, held stable from ISSUE to DONE
- reg_sdmabuffb  out  3  payload sdmabuffb to register, held stable from ISSUE to DONE
- reg_ack  in  1  register ack (register contents == driven payload)
- reg_busy  in  1  register busy (more than one enable high)

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; gnt, done, err, reg_enb = 0; payload register = 0; timeout counter = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Reset mid-transaction aborts silently: no done or err pulse. The register keeps whatever it captured.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req != 0, select the first set bit scanning from pointer upward, wrapping 2->0.
  - Latch index and that requester's wdata; go to ISSUE.
  - If req == 0, stay.
- ISSUE (exactly 1 cycle):
  - reg_enb[idx]=1 and gnt[idx]=1; the register captures the payload at the end of this cycle.
  - If reg_busy is high, set an internal error flag.
  - Go to WAIT; clear the counter.
- WAIT:
  - If reg_ack=1, go to DONE with success.
  - Else increment the counter; when counter == TIMEOUT-1 and ack is still low, go to DONE with the error flag set.
  - reg_ack is ignored in IDLE and ISSUE (it may be stale-high when the payload equals the old contents).
- DONE (1 cycle):
  - done[idx]=1; err = error flag.
  - Pointer = (idx+1) mod 3; clear the flag; go to IDLE.
- Latency: req seen in IDLE at cycle N -> reg_enb at N+1 -> done at N+3 minimum. A new grant is issued no earlier than N+4.
- Payload is latched in IDLE and not resampled. wdata changes or a req drop after selection do not affect the in-flight write, which completes and pulses done.
- A requester holding req high after done is re-arbitrated normally; it cannot win twice in a row while another requester is waiting.
- Outputs gnt, reg_enb, done and err are decoded from the registered state/idx; there are no combinational paths from req or reg_ack to outputs.
- Counter width is ceil(log2(TIMEOUT)) bits and never wraps: saturate / exit at TIMEOUT-1.

Decomposition:
- Package reg16_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - DW
  - field offsets BSIZE_LSB=0, BSIZE_W=12, BUFFB_LSB=12, BUFFB_W=3
  - NREQ=3
- One sub-module, rr_arb3: combinational round-robin pick. Inputs req[2:0], ptr[1:0]; outputs valid, idx[1:0].
- FSM, payload latch and counter live in the top module.

Test Plan:
- Reset then req=3'b001, wdata0=15'h2200 with a register model returning ack one cycle after capture -> reg_enb=001 at cycle 1, reg_bsize=12'h200, reg_sdmabuffb=3'b010, done=001 at cycle 3, err=0, busy high cycles 1-3.
- req=3'b111 held for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2. reg_enb is never more than one-hot; reg_busy is never seen high.
- Register model holds ack low with TIMEOUT=8 -> done and err pulse exactly 8 WAIT cycles after ISSUE; state returns to IDLE.
- req1 set with wdata1=15'h0FFF, then wdata1 changed to 15'h7000 and req1 dropped the cycle after selection -> register receives 12'hFFF / 3'b000; done=010 still pulses.
- rst asserted during WAIT -> next cycle all outputs 0, no done or err pulse. With req=3'b110 afterwards, requester 1 is granted first (pointer reset to 0).
- Payload equal to current register contents (ack already high in IDLE) -> write still issued; done no earlier than cycle N+3.

Source files
------------

// File: rtl/reg16_pkg.sv
// reg16_pkg: shared types and field layout for the SDMA boundary/block-size write arbiter.
package reg16_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int DW = 15;
  localparam int BSIZE_LSB = 0;
  localparam int BSIZE_W = 12;
  localparam int BUFFB_LSB = 12;
  localparam int BUFFB_W = 3;
  localparam int NREQ = 3;
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: combinational three-way round-robin pick starting at ptr.
module rr_arb3
  import reg16_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      idx
);
  logic [1:0] p0, p1, p2;
  assign p0 = ptr == 2'd3 ? 2'd0 : ptr;
  assign p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
  assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
  assign valid = |req;
  assign idx = req[p0] ? p0 : req[p1] ? p1 : p2;
endmodule

// File: rtl/reg16_004_write_arbiter.sv
// reg16_004_write_arbiter: round-robin arbiter issuing one register write at a time and reporting done/err.
module reg16_004_write_arbiter
  import reg16_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [DW-1:0]       wdata0,
  input  logic [DW-1:0]       wdata1,
  input  logic [DW-1:0]       wdata2,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic                busy,
  output logic [NREQ-1:0]     reg_enb,
  output logic [BSIZE_W-1:0]  reg_bsize,
  output logic [BUFFB_W-1:0]  reg_sdmabuffb,
  input  logic                reg_ack,
  input  logic                reg_busy
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state;
  logic [1:0] idx, ptr, pick;
  logic valid, eflag;
  logic [DW-1:0] payload;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] oh;
  rr_arb3 u_arb (.req(req), .ptr(ptr), .valid(valid), .idx(pick));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      ptr <= '0;
      payload <= '0;
      cnt <= '0;
      eflag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          idx <= pick;
          payload <= pick == 2'd0 ? wdata0 : pick == 2'd1 ? wdata1 : wdata2;
          state <= ISSUE;
        end
        ISSUE: begin
          eflag <= reg_busy;
          cnt <= '0;
          state <= WAIT;
        end
        // ack is only trusted here, after the register has captured the payload
        WAIT: if (reg_ack) state <= DONE;
          else if (cnt == CW'(TIMEOUT - 1)) begin
            eflag <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + 1'b1;
        DONE: begin
          ptr <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
          eflag <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign oh = NREQ'(3'b001 << idx);
  assign busy = state != IDLE;
  assign gnt = busy ? oh : '0;
  assign reg_enb = state == ISSUE ? oh : '0;
  assign done = state == DONE ? oh : '0;
  assign err = state == DONE && eflag;
  assign reg_bsize = payload[BSIZE_LSB +: BSIZE_W];
  assign reg_sdmabuffb = payload[BUFFB_LSB +: BUFFB_W];
endmodule
